// File: rtl/enigma_pkg.sv
// Shared types, defaults and modular helpers for the Enigma rotor stage.
package enigma_pkg;

    localparam int unsigned ALPHA_DEF = 26;
    localparam int unsigned W_DEF     = 6;
    localparam int unsigned NOTCH_DEF = 16;

    // Working width for modular arithmetic; wide enough for any W up to 15.
    localparam int unsigned MOD_W     = 16;

    typedef logic [W_DEF-1:0] symbol_t;
    typedef logic [MOD_W-1:0] modval_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BUILD = 1'b1
    } build_state_t;

    // (a + b) mod n for a, b < n: one conditional subtraction.
    function automatic modval_t mod_add(input modval_t a, input modval_t b, input modval_t n);
        modval_t s;
        s = a + b;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

    // (a - b) mod n for a, b < n: one conditional addition.
    function automatic modval_t mod_sub(input modval_t a, input modval_t b, input modval_t n);
        modval_t d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = a + n - b;
        end
        return d;
    endfunction

endpackage

// File: rtl/enigma_rotor_map.sv
// Combinational rotor lookup: offset into the wiring table, then offset back out.
module enigma_rotor_map
    import enigma_pkg::*;
#(
    parameter int unsigned ALPHA = ALPHA_DEF,
    parameter int unsigned W     = W_DEF
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] pos,
    input  logic [W-1:0] ring,
    input  logic [W-1:0] tab [ALPHA],
    output logic [W-1:0] y
);

    localparam int unsigned AW = (ALPHA > 1) ? $clog2(ALPHA) : 1;
    localparam modval_t     N  = modval_t'(ALPHA);

    logic [AW-1:0] k;
    logic [W-1:0]  t;

    // k = x + pos - ring, t = tab[k], y = t - pos + ring (all mod ALPHA)
    always_comb begin
        k = AW'(mod_sub(mod_add(modval_t'(x), modval_t'(pos), N), modval_t'(ring), N));
        t = tab[k];
        y = W'(mod_add(mod_sub(modval_t'(t), modval_t'(pos), N), modval_t'(ring), N));
    end

endmodule

// File: rtl/enigma_rotor_bidir.sv
// Enigma rotor stage: loadable wiring, inverse-table builder, position/notch and lookup pipe.
module enigma_rotor_bidir
    import enigma_pkg::*;
#(
    parameter int unsigned ALPHA     = ALPHA_DEF,
    parameter int unsigned W         = W_DEF,
    parameter int unsigned NOTCH_RST = NOTCH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_we,
    input  logic [W-1:0] cfg_addr,
    input  logic [W-1:0] cfg_data,
    input  logic [W-1:0] cfg_ring,
    input  logic [W-1:0] cfg_notch,
    input  logic         cfg_set,
    input  logic         build,
    output logic         busy,
    output logic         cfg_err,
    input  logic         pos_load,
    input  logic [W-1:0] pos_in,
    output logic [W-1:0] pos,
    input  logic         step_in,
    output logic         step_out,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_dir,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_err
);

    localparam int unsigned AW = (ALPHA > 1) ? $clog2(ALPHA) : 1;

    logic [W-1:0]     fwd_q [ALPHA];
    logic [W-1:0]     inv_q [ALPHA];
    logic [W-1:0]     map_tab [ALPHA];
    logic [ALPHA-1:0] seen_q;
    logic             inv_ok_q;
    logic [AW-1:0]    idx_q;
    build_state_t     state_q;
    build_state_t     state_d;
    logic             build_start;
    logic             build_step;
    logic             build_done;
    logic [W-1:0]     build_val;
    logic             build_oor;
    logic             build_bad;
    logic             cfg_acc;
    logic             wr_en;
    logic [W-1:0]     pos_q;
    logic [W-1:0]     ring_q;
    logic [W-1:0]     notch_q;
    logic [W-1:0]     pos_in_red;
    logic             busy_q;
    logic             cfg_err_q;
    logic             out_valid_q;
    logic [W-1:0]     out_data_q;
    logic             out_err_q;
    logic             accept;
    logic             req_err;
    logic [W-1:0]     map_y;

    // Build FSM next-state and control strobes
    always_comb begin
        state_d     = state_q;
        build_start = 1'b0;
        build_step  = 1'b0;
        build_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (build) begin
                    build_start = 1'b1;
                    state_d     = ST_BUILD;
                end
            end
            ST_BUILD: begin
                build_step = 1'b1;
                if (idx_q == AW'(ALPHA - 1)) begin
                    build_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Build FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Current build entry and its validity against the alphabet and already-seen values
    always_comb begin
        build_val = fwd_q[idx_q];
        build_oor = (build_val >= W'(ALPHA));
        build_bad = build_oor || seen_q[AW'(build_val)];
        cfg_acc   = cfg_we & ~busy_q;
        wr_en     = cfg_acc & (cfg_addr < W'(ALPHA));
    end

    // Forward wiring writes and inverse-table fills; both reset to identity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ALPHA; i++) begin
                fwd_q[i] <= W'(i);
                inv_q[i] <= W'(i);
            end
        end else begin
            if (wr_en) begin
                fwd_q[AW'(cfg_addr)] <= cfg_data;
            end
            if (build_step && !build_oor) begin
                inv_q[AW'(build_val)] <= W'(idx_q);
            end
        end
    end

    // Duplicate detector for the permutation check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= '0;
        end else if (build_start) begin
            seen_q <= '0;
        end else if (build_step && !build_oor) begin
            seen_q[AW'(build_val)] <= 1'b1;
        end
    end

    // Build index, busy flag, sticky error and inverse-valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            busy_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            inv_ok_q  <= 1'b1;
        end else begin
            busy_q <= (state_d == ST_BUILD);
            if (build_start) begin
                idx_q <= '0;
            end else if (build_step && !build_done) begin
                idx_q <= idx_q + AW'(1);
            end
            if (build_start) begin
                cfg_err_q <= 1'b0;
            end else if (build_step && build_bad) begin
                cfg_err_q <= 1'b1;
            end else if (cfg_acc && (cfg_data >= W'(ALPHA))) begin
                cfg_err_q <= 1'b1;
            end
            if (build_done) begin
                inv_ok_q <= ~(cfg_err_q | build_bad);
            end else if (cfg_acc) begin
                inv_ok_q <= 1'b0;
            end
        end
    end

    // Position update; an out-of-range load is folded by one subtraction
    always_comb begin
        pos_in_red = (pos_in >= W'(ALPHA)) ? (pos_in - W'(ALPHA)) : pos_in;
    end

    // Position, ring and notch registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q   <= '0;
            ring_q  <= '0;
            notch_q <= W'(NOTCH_RST);
        end else begin
            if (pos_load) begin
                pos_q <= pos_in_red;
            end else if (step_in) begin
                pos_q <= (pos_q == W'(ALPHA - 1)) ? '0 : (pos_q + W'(1));
            end
            if (cfg_set) begin
                ring_q  <= cfg_ring;
                notch_q <= cfg_notch;
            end
        end
    end

    // Select forward or inverse table for the single lookup datapath
    always_comb begin
        for (int unsigned i = 0; i < ALPHA; i++) begin
            map_tab[i] = in_dir ? inv_q[i] : fwd_q[i];
        end
    end

    enigma_rotor_map #(
        .ALPHA (ALPHA),
        .W     (W)
    ) u_map (
        .x    (in_data),
        .pos  (pos_q),
        .ring (ring_q),
        .tab  (map_tab),
        .y    (map_y)
    );

    // Handshake and unmappable-request detection
    always_comb begin
        in_ready = ~busy_q & (~out_valid_q | out_ready);
        accept   = in_valid & in_ready;
        req_err  = (in_data >= W'(ALPHA)) | (in_dir & ~inv_ok_q);
        step_out = step_in & (pos_q == notch_q);
    end

    // Output register; holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= req_err ? in_data : map_y;
            out_err_q   <= req_err;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign busy      = busy_q;
    assign cfg_err   = cfg_err_q;
    assign pos       = pos_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule
